nfu2_accum_ctrl: RTL and testbench
==================================

NFU2_ACCUM_CTRL -- requirements
Module: nfu2_accum_ctrl

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, meaning datapath word width; it has no effect on control and is carried for instantiation consistency.
REQ-002 The block SHALL have parameter PASS_W, default 8, meaning the width of the pass count and pass index.
REQ-003 The block SHALL have parameter PIPE_LAT, default 2, meaning the cycles from an accepted multiplier pass to its effect landing in the partial-sum register; legal range 1..15.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port i_start, input, 1: job request; sampled only in IDLE.
REQ-007 Port i_num_passes, input, PASS_W: number of accumulation passes in the job; sampled with i_start.
REQ-008 Port o_busy, output, 1: high in every state except IDLE.
REQ-009 Port o_nb_rd_en, output, 1: request for the initial partial sum from NBout.
REQ-010 Port i_nb_rd_valid, input, 1: the NBout partial sum is present on the datapath partial-sum input this cycle.
REQ-011 Port o_load_partial_sum, output, 1: drives the datapath load-partial-sum select.
REQ-012 Port i_mult_valid, input, 1: the multiplier products and select lines for one pass are valid.
REQ-013 Port o_mult_ready, output, 1: the controller accepts a pass this cycle.
REQ-014 Port o_nfu1_en, output, 1: when 0, the wrapper forces the NFU-1 products to zero so the accumulation adds 0.
REQ-015 Port o_pass_idx, output, PASS_W: index of the pass being accepted, used to address the L1/L2 select-line storage.
REQ-016 Port o_out_valid, output, 1: the accumulated result on the datapath output is final.
REQ-017 Port i_out_ready, input, 1: the consumer accepts the result.
REQ-018 Port o_done, output, 1: one-cycle pulse on result handoff.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, LOAD, ACCUM, DRAIN, OUT.
REQ-020 In IDLE, i_start=1 with i_num_passes!=0 SHALL latch the pass count, clear the pass index to 0, and go to LOAD next cycle; i_start with i_num_passes=0 SHALL be ignored (stay IDLE).
REQ-021 In LOAD, o_nb_rd_en SHALL be 1; on the cycle i_nb_rd_valid=1, o_load_partial_sum SHALL be 1 combinationally and the FSM SHALL go to ACCUM.
REQ-022 o_load_partial_sum SHALL be 0 in all other cycles and states.
REQ-023 In ACCUM, o_mult_ready SHALL be 1; a pass SHALL be accepted when i_mult_valid & o_mult_ready.
REQ-024 o_nfu1_en SHALL equal i_mult_valid & o_mult_ready (combinational), so bubbles accumulate zero.
REQ-025 o_pass_idx SHALL equal the number of passes already accepted in the job; it increments by 1 per accepted pass and never wraps within a job.
REQ-026 On acceptance of pass number (count-1), the FSM SHALL go to DRAIN and load a drain counter with PIPE_LAT.
REQ-027 In DRAIN, o_mult_ready SHALL be 0 and o_nfu1_en SHALL be 0; the counter decrements each cycle and the FSM SHALL enter OUT on the cycle after the counter reads 1.
REQ-028 In OUT, o_out_valid SHALL be 1 and o_nfu1_en SHALL be 0; o_out_valid SHALL hold until i_out_ready=1.
REQ-029 On the OUT cycle with i_out_ready=1, o_done SHALL pulse for that cycle and the FSM SHALL return to IDLE.
REQ-030 i_start SHALL be ignored whenever o_busy=1.
REQ-031 i_nb_rd_valid outside LOAD SHALL be ignored, and i_mult_valid outside ACCUM SHALL be ignored.
REQ-032 o_mult_ready, o_out_valid and o_nb_rd_en SHALL be registered-state decodes with no combinational path from i_mult_valid, i_out_ready or i_nb_rd_valid.
REQ-033 A job with i_num_passes=2^PASS_W-1 (255) SHALL complete correctly, with o_pass_idx reaching 254 on the final accepted pass.

Reset
REQ-034 With rst=1 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-ACCUM or mid-DRAIN, and clear the pass index, pass count and drain counter.
REQ-035 During and after reset, every output SHALL be 0 until a new job starts.
REQ-036 rst SHALL take priority over i_start in the same cycle.

Verification
REQ-037 Scenario: i_start with passes=3, i_nb_rd_valid on the 2nd LOAD cycle, i_mult_valid continuously -> one o_load_partial_sum pulse; o_pass_idx = 0, 1, 2; DRAIN lasts 2 cycles; o_out_valid then asserts.
REQ-038 Scenario: passes=4 with i_mult_valid pattern 1,0,0,1,1,0,1 -> exactly 4 cycles with o_nfu1_en=1; o_pass_idx advances only on those cycles.
REQ-039 Scenario: in OUT, hold i_out_ready=0 for 5 cycles, then 1 -> o_out_valid stays high for 6 cycles; o_done pulses once on the 6th; FSM returns to IDLE.
REQ-040 Scenario: i_start with passes=0, and i_start asserted while busy -> no state change, and the running job is unaffected.
REQ-041 Scenario: rst asserted during the 2nd ACCUM cycle of a passes=5 job -> all outputs 0 the next cycle; a fresh passes=1 job then completes normally.
REQ-042 Scenario: passes=255 run back-to-back with PIPE_LAT=1 -> 255 accepts, a 1-cycle DRAIN, and o_done pulses once.

Source files
------------

// File: rtl/nfu2_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nfu2_accum_ctrl
// Description : NFU-2 accumulation controller. It sequences the partial-sum
//               load, multiplier passes, pipeline drain and result handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module nfu2_accum_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int PASS_W    = 8,
    parameter int PIPE_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [PASS_W-1:0] i_num_passes,
    output logic              o_busy,
    output logic              o_nb_rd_en,
    input  logic              i_nb_rd_valid,
    output logic              o_load_partial_sum,
    input  logic              i_mult_valid,
    output logic              o_mult_ready,
    output logic              o_nfu1_en,
    output logic [PASS_W-1:0] o_pass_idx,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [3:0] c_DRAIN_ONE = 4'd1;

    state_t            r_state_q, w_state_d;
    logic [PASS_W-1:0] r_count_q, w_count_d;
    logic [PASS_W-1:0] r_pass_idx_q, w_pass_idx_d;
    logic [3:0]        r_drain_q, w_drain_d;
    logic [3:0]        w_drain_init;
    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic              w_done;

    // Out-of-range configurations fall back to a one-cycle drain.
    if (BIT_WIDTH > 0 && PIPE_LAT >= 1 && PIPE_LAT <= 15) begin : g_drain_init
        assign w_drain_init = 4'(PIPE_LAT);
    end else begin : g_drain_min
        assign w_drain_init = c_DRAIN_ONE;
    end

    assign o_busy             = (r_state_q != S_IDLE);
    assign o_nb_rd_en         = (r_state_q == S_LOAD);
    assign o_mult_ready       = (r_state_q == S_ACCUM);
    assign o_out_valid        = (r_state_q == S_OUT);
    assign o_pass_idx         = r_pass_idx_q;
    assign o_load_partial_sum = w_load;
    assign o_done             = w_done;
    assign w_accept           = i_mult_valid & o_mult_ready;
    assign o_nfu1_en          = w_accept;
    assign w_last             = (r_pass_idx_q == (r_count_q - PASS_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_count_q    <= '0;
            r_pass_idx_q <= '0;
            r_drain_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_count_q    <= w_count_d;
            r_pass_idx_q <= w_pass_idx_d;
            r_drain_q    <= w_drain_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_count_d    = r_count_q;
        w_pass_idx_d = r_pass_idx_q;
        w_drain_d    = r_drain_q;
        w_load       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state_q)
            S_IDLE: begin
                if (i_start && (i_num_passes != '0)) begin
                    w_count_d    = i_num_passes;
                    w_pass_idx_d = '0;
                    w_state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_nb_rd_valid) begin
                    w_load    = 1'b1;
                    w_state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    w_pass_idx_d = r_pass_idx_q + PASS_W'(1);
                    if (w_last) begin
                        w_state_d = S_DRAIN;
                        w_drain_d = w_drain_init;
                    end
                end
            end
            S_DRAIN: begin
                // The final pass lands while the counter reads 1.
                w_drain_d = r_drain_q - 4'd1;
                if (r_drain_q == c_DRAIN_ONE) begin
                    w_state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_done    = 1'b1;
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nfu2_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nfu2_accum_ctrl
// Description : Job-level checker for nfu2_accum_ctrl (PIPE_LAT 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nfu2_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_num_passes = 8'd0;
    logic       i_nb_rd_valid = 1'b0;
    logic       i_mult_valid = 1'b0;
    logic       i_out_ready = 1'b0;
    logic       sel = 1'b0;

    logic       a_busy, a_rd, a_load, a_rdy, a_nfu, a_ov, a_done;
    logic [7:0] a_idx;
    logic       b_busy, b_rd, b_load, b_rdy, b_nfu, b_ov, b_done;
    logic [7:0] b_idx;
    logic       m_busy, m_rd, m_load, m_rdy, m_nfu, m_ov, m_done;
    logic [7:0] m_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nfu2_accum_ctrl #(.BIT_WIDTH(16), .PASS_W(8), .PIPE_LAT(2)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_passes(i_num_passes),
        .o_busy(a_busy), .o_nb_rd_en(a_rd), .i_nb_rd_valid(i_nb_rd_valid),
        .o_load_partial_sum(a_load), .i_mult_valid(i_mult_valid),
        .o_mult_ready(a_rdy), .o_nfu1_en(a_nfu), .o_pass_idx(a_idx),
        .o_out_valid(a_ov), .i_out_ready(i_out_ready), .o_done(a_done)
    );

    nfu2_accum_ctrl #(.BIT_WIDTH(16), .PASS_W(8), .PIPE_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_passes(i_num_passes),
        .o_busy(b_busy), .o_nb_rd_en(b_rd), .i_nb_rd_valid(i_nb_rd_valid),
        .o_load_partial_sum(b_load), .i_mult_valid(i_mult_valid),
        .o_mult_ready(b_rdy), .o_nfu1_en(b_nfu), .o_pass_idx(b_idx),
        .o_out_valid(b_ov), .i_out_ready(i_out_ready), .o_done(b_done)
    );

    assign m_busy = sel ? b_busy : a_busy;
    assign m_rd   = sel ? b_rd   : a_rd;
    assign m_load = sel ? b_load : a_load;
    assign m_rdy  = sel ? b_rdy  : a_rdy;
    assign m_nfu  = sel ? b_nfu  : a_nfu;
    assign m_idx  = sel ? b_idx  : a_idx;
    assign m_ov   = sel ? b_ov   : a_ov;
    assign m_done = sel ? b_done : a_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job as seen from outside: a single partial-sum load, n accepted passes
    // indexed 0..n-1, PIPE_LAT drain cycles, then a held result until accepted.
    task automatic do_job(input int n, input int rd_wait, input int out_wait, input int vprob,
                          input logic [31:0] pat, input int patlen, input bit noise);
        int acc, cyc, nfu, lat;
        bit v;
        lat = sel ? 1 : 2;
        i_start = 1'b1;
        i_num_passes = 8'(n);
        #1;
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL start_idle busy got %b exp 0", m_busy); end
        step();
        i_start = noise;
        for (int k = 0; k <= rd_wait; k++) begin
            i_nb_rd_valid = (k == rd_wait);
            i_mult_valid = noise ? 1'($urandom) : 1'b0;
            i_num_passes = 8'($urandom);
            #1;
            checks++; if (m_rd !== 1'b1) begin errors++; $display("FAIL load_rd_en got %b exp 1", m_rd); end
            checks++; if (m_load !== (k == rd_wait)) begin errors++; $display("FAIL load_pulse got %b exp %b", m_load, (k == rd_wait)); end
            checks++; if (m_nfu !== 1'b0) begin errors++; $display("FAIL load_nfu1 got %b exp 0", m_nfu); end
            step();
        end
        i_nb_rd_valid = 1'b0;
        acc = 0; cyc = 0; nfu = 0;
        while (acc < n && cyc < n * 50 + 100) begin
            if (patlen > 0) v = (cyc < patlen) ? pat[cyc] : 1'b1;
            else v = ($urandom_range(99) < vprob);
            i_mult_valid = v;
            i_nb_rd_valid = noise ? 1'($urandom) : 1'b0;
            #1;
            checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL accum_ready got %b exp 1", m_rdy); end
            checks++; if (m_idx !== 8'(acc)) begin errors++; $display("FAIL pass_idx got %0d exp %0d", m_idx, acc); end
            checks++; if (m_nfu !== v) begin errors++; $display("FAIL accum_nfu1 got %b exp %b", m_nfu, v); end
            checks++; if (m_load !== 1'b0) begin errors++; $display("FAIL accum_load got %b exp 0", m_load); end
            if (m_nfu === 1'b1) nfu++;
            if (v) acc++;
            cyc++;
            step();
        end
        checks++; if (acc != n) begin errors++; $display("FAIL accept_budget got %0d exp %0d", acc, n); end
        checks++; if (nfu != n) begin errors++; $display("FAIL nfu1_cycles got %0d exp %0d", nfu, n); end
        i_nb_rd_valid = 1'b0;
        for (int d = 0; d < lat; d++) begin
            i_mult_valid = noise ? 1'($urandom) : 1'b1;
            #1;
            checks++; if (m_rdy !== 1'b0 || m_nfu !== 1'b0) begin errors++; $display("FAIL drain_ready rdy %b nfu %b exp 0 0", m_rdy, m_nfu); end
            checks++; if (m_ov !== 1'b0 || m_busy !== 1'b1) begin errors++; $display("FAIL drain_state ov %b busy %b exp 0 1", m_ov, m_busy); end
            checks++; if (m_idx !== 8'(n)) begin errors++; $display("FAIL drain_idx got %0d exp %0d", m_idx, n); end
            step();
        end
        for (int k = 0; k <= out_wait; k++) begin
            i_out_ready = (k == out_wait);
            if (k == out_wait) i_start = 1'b0;
            #1;
            checks++; if (m_ov !== 1'b1) begin errors++; $display("FAIL out_valid got %b exp 1", m_ov); end
            checks++; if (m_done !== (k == out_wait)) begin errors++; $display("FAIL out_done got %b exp %b", m_done, (k == out_wait)); end
            checks++; if (m_nfu !== 1'b0) begin errors++; $display("FAIL out_nfu1 got %b exp 0", m_nfu); end
            step();
        end
        i_out_ready = 1'b0;
        i_mult_valid = 1'b0;
        i_start = 1'b0;
        #1;
        checks++; if (m_busy !== 1'b0 || m_ov !== 1'b0 || m_done !== 1'b0) begin
            errors++; $display("FAIL job_end busy %b ov %b done %b exp 0 0 0", m_busy, m_ov, m_done);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        i_start = 1'b1;
        i_num_passes = 8'd3;
        step();
        step();
        checks++; if ({m_busy, m_rd, m_load, m_rdy, m_nfu, m_ov, m_done} !== 7'd0 || m_idx !== 8'd0) begin
            errors++; $display("FAIL reset_outputs got %b idx %0d exp 0", {m_busy, m_rd, m_load, m_rdy, m_nfu, m_ov, m_done}, m_idx);
        end
        rst = 1'b0;
        i_start = 1'b0;
        step();
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_priority busy got %b exp 0", m_busy); end
    endtask

    task automatic test_basic();
        do_job(3, 1, 0, 100, 32'd0, 0, 1'b0);
    endtask

    task automatic test_bubbles();
        do_job(4, 0, 0, 0, 32'b1011001, 7, 1'b0);
    endtask

    task automatic test_out_hold();
        do_job(2, 0, 5, 100, 32'd0, 0, 1'b0);
    endtask

    task automatic test_ignore();
        i_start = 1'b1;
        i_num_passes = 8'd0;
        step();
        step();
        checks++; if (m_busy !== 1'b0 || m_rd !== 1'b0) begin errors++; $display("FAIL zero_pass busy %b rd %b exp 0 0", m_busy, m_rd); end
        i_start = 1'b0;
        do_job(5, 2, 1, 60, 32'd0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1;
        i_num_passes = 8'd5;
        step();
        i_start = 1'b0;
        i_nb_rd_valid = 1'b1;
        step();
        i_nb_rd_valid = 1'b0;
        i_mult_valid = 1'b1;
        step();
        rst = 1'b1;
        #1;
        checks++; if (m_idx !== 8'd1 || m_rdy !== 1'b1) begin errors++; $display("FAIL mid_accum idx %0d rdy %b exp 1 1", m_idx, m_rdy); end
        step();
        checks++; if ({m_busy, m_rd, m_load, m_rdy, m_nfu, m_ov, m_done} !== 7'd0 || m_idx !== 8'd0) begin
            errors++; $display("FAIL mid_reset got %b idx %0d exp 0", {m_busy, m_rd, m_load, m_rdy, m_nfu, m_ov, m_done}, m_idx);
        end
        rst = 1'b0;
        i_mult_valid = 1'b0;
        step();
        do_job(1, 0, 0, 100, 32'd0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            do_job($urandom_range(12, 1), $urandom_range(3), $urandom_range(3),
                   $urandom_range(100, 40), 32'd0, 0, 1'($urandom));
            step();
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        do_job(255, 0, 0, 100, 32'd0, 0, 1'b0);
        sel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_out_hold();
        test_ignore();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
